// File: rtl/inport_buf_rc.sv
// inport_buf_rc
//
// Input-port receiver for one router port. Buffers flits arriving from the
// upstream neighbour in a small circular FIFO, returns a ready signal
// upstream, performs XY route computation on head flits and holds the
// computed route for the rest of the packet so the switch allocator sees a
// stable request. One flit is dequeued per allocator grant.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   valid_in  upstream flit present this cycle
//   flit_in   incoming flit; [DATA_W-1:DATA_W-2] = type (01 head, 00 body,
//             10 tail, 11 single), then dst_x, then dst_y
//   grnt_out  ready to upstream (not full and not in reset)
//   sw_grant  allocator granted this port; pops the FIFO head
//   flit_out  FIFO head flit
//   rc_req    route request: 001 Local, 010 East, 011 West, 100 North,
//             101 South, 000 none
//   count     FIFO occupancy
//   ovf       sticky: flit arrived while full (flit dropped)
//   err       sticky: body/tail flit found at the head outside a packet
module inport_buf_rc #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int AW      = 2,
    parameter int COORD_W = 4,
    parameter int MY_X    = 0,
    parameter int MY_Y    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] flit_in,
    output logic              grnt_out,
    input  logic              sw_grant,
    output logic [DATA_W-1:0] flit_out,
    output logic [2:0]        rc_req,
    output logic [AW:0]       count,
    output logic              ovf,
    output logic              err
);

    localparam logic [1:0] FT_BODY   = 2'b00;
    localparam logic [1:0] FT_HEAD   = 2'b01;
    localparam logic [1:0] FT_TAIL   = 2'b10;
    localparam logic [1:0] FT_SINGLE = 2'b11;

    localparam logic [2:0] RC_NONE  = 3'b000;
    localparam logic [2:0] RC_LOCAL = 3'b001;
    localparam logic [2:0] RC_EAST  = 3'b010;
    localparam logic [2:0] RC_WEST  = 3'b011;
    localparam logic [2:0] RC_NORTH = 3'b100;
    localparam logic [2:0] RC_SOUTH = 3'b101;

    localparam logic [AW:0]        FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]        CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]      PTR_ONE  = AW'(1);
    localparam logic [COORD_W-1:0] MY_X_C   = COORD_W'(MY_X);
    localparam logic [COORD_W-1:0] MY_Y_C   = COORD_W'(MY_Y);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Dimension-ordered routing: resolve X first, then Y, unsigned compares.
    function automatic logic [2:0] xy_route(input logic [COORD_W-1:0] dx,
                                            input logic [COORD_W-1:0] dy);
        logic [2:0] r;
        if (dx > MY_X_C)      r = RC_EAST;
        else if (dx < MY_X_C) r = RC_WEST;
        else if (dy > MY_Y_C) r = RC_NORTH;
        else if (dy < MY_Y_C) r = RC_SOUTH;
        else                  r = RC_LOCAL;
        return r;
    endfunction

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    state_t             state;
    logic [2:0]         route_q;

    logic               empty;
    logic               full;
    logic               push;
    logic               pop;
    logic               bad_head;
    logic               head_like;
    logic [1:0]         head_type;
    logic [COORD_W-1:0] dst_x;
    logic [COORD_W-1:0] dst_y;
    logic [2:0]         head_route;

    assign flit_out   = mem[rd_ptr];
    assign head_type  = flit_out[DATA_W-1 -: 2];
    assign dst_x      = flit_out[DATA_W-3 -: COORD_W];
    assign dst_y      = flit_out[DATA_W-3-COORD_W -: COORD_W];
    assign head_route = xy_route(dst_x, dst_y);

    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    // Ready reflects current occupancy only; a same-cycle pop frees the slot
    // for the following cycle, which keeps grnt_out off the sw_grant path.
    assign grnt_out  = reset & ~full;
    assign push      = valid_in & grnt_out;
    assign head_like = (head_type == FT_HEAD) | (head_type == FT_SINGLE);
    // A body/tail flit at the head outside a packet can never be routed, so
    // it is dropped on its own to keep the port from stalling forever.
    assign bad_head  = (state == IDLE) & ~empty & ~head_like;
    assign pop       = (sw_grant & ~empty) | bad_head;

    always_comb begin
        rc_req = RC_NONE;
        if (!empty) begin
            if (state == ACTIVE) rc_req = route_q;
            else if (head_like)  rc_req = head_route;
        end
    end

    // Flit storage: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= flit_in;
    end

    // Control: pointers, occupancy, packet FSM and sticky flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            state   <= IDLE;
            route_q <= RC_NONE;
            ovf     <= 1'b0;
            err     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;

            if (push && !pop)      count <= count + CNT_ONE;
            else if (!push && pop) count <= count - CNT_ONE;

            if (pop) begin
                case (state)
                    IDLE: begin
                        // Single flits complete in one pop and leave us IDLE.
                        if (head_type == FT_HEAD) begin
                            route_q <= head_route;
                            state   <= ACTIVE;
                        end
                    end
                    ACTIVE: begin
                        // Stray head/single flits mid-packet ride as body.
                        if (head_type == FT_TAIL) state <= IDLE;
                    end
                endcase
            end

            if (bad_head)          err <= 1'b1;
            if (valid_in && full)  ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_inport_buf_rc.sv
// tb_inport_buf_rc
//
// Self-checking bench for inport_buf_rc (MY_X=2, MY_Y=2). A queue-based
// reference model tracks the buffered flits, the packet state and the sticky
// flags; each scenario task drives stimulus and compares DUT outputs inline.
module tb_inport_buf_rc;
    localparam int DATA_W  = 32;
    localparam int DEPTH   = 4;
    localparam int AW      = 2;
    localparam int COORD_W = 4;
    localparam int MY_X    = 2;
    localparam int MY_Y    = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              valid_in = 1'b0;
    logic              sw_grant = 1'b0;
    logic [DATA_W-1:0] flit_in = '0;
    logic [DATA_W-1:0] flit_out;
    logic              grnt_out;
    logic [2:0]        rc_req;
    logic [AW:0]       count;
    logic              ovf;
    logic              err;

    always #5 clk = ~clk;

    inport_buf_rc #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW),
        .COORD_W(COORD_W), .MY_X(MY_X), .MY_Y(MY_Y)
    ) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .flit_in(flit_in),
        .grnt_out(grnt_out), .sw_grant(sw_grant), .flit_out(flit_out),
        .rc_req(rc_req), .count(count), .ovf(ovf), .err(err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [DATA_W-1:0] mq[$];
    bit                m_pkt;
    logic [2:0]        m_route;
    bit                m_ovf;
    bit                m_err;

    function automatic logic [DATA_W-1:0] mk(input logic [1:0] t, input int dx, input int dy);
        logic [DATA_W-1:0] f;
        f = $urandom;
        f[DATA_W-1 -: 2] = t;
        f[DATA_W-3 -: COORD_W] = COORD_W'(dx);
        f[DATA_W-3-COORD_W -: COORD_W] = COORD_W'(dy);
        return f;
    endfunction

    function automatic logic [2:0] xy(input logic [DATA_W-1:0] f);
        int dx;
        int dy;
        dx = int'(f[DATA_W-3 -: COORD_W]);
        dy = int'(f[DATA_W-3-COORD_W -: COORD_W]);
        if (dx > MY_X) return 3'b010;
        if (dx < MY_X) return 3'b011;
        if (dy > MY_Y) return 3'b100;
        if (dy < MY_Y) return 3'b101;
        return 3'b001;
    endfunction

    function automatic bit starts_pkt(input logic [DATA_W-1:0] f);
        return (f[DATA_W-1 -: 2] == 2'b01) || (f[DATA_W-1 -: 2] == 2'b11);
    endfunction

    function automatic logic [2:0] m_rc();
        if (mq.size() == 0) return 3'b000;
        if (m_pkt) return m_route;
        if (starts_pkt(mq[0])) return xy(mq[0]);
        return 3'b000;
    endfunction

    // Advance the model by one clock using the current inputs, then let the
    // DUT take the same edge; returns 1 ns after the edge.
    task automatic tick();
        bit do_push;
        logic [DATA_W-1:0] h;
        if (reset) begin
            do_push = valid_in && (mq.size() < DEPTH);
            if (valid_in && mq.size() == DEPTH) m_ovf = 1;
            if (mq.size() != 0) begin
                h = mq[0];
                if (!m_pkt && !starts_pkt(h)) begin
                    m_err = 1;
                    void'(mq.pop_front());
                end else if (sw_grant) begin
                    if (!m_pkt && h[DATA_W-1 -: 2] == 2'b01) begin
                        m_pkt = 1;
                        m_route = xy(h);
                    end else if (m_pkt && h[DATA_W-1 -: 2] == 2'b10) begin
                        m_pkt = 0;
                    end
                    void'(mq.pop_front());
                end
            end
            if (do_push) mq.push_back(flit_in);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        mq.delete();
        m_pkt = 0;
        m_route = 3'b000;
        m_ovf = 0;
        m_err = 0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        valid_in = 1'b1;
        sw_grant = 1'b0;
        for (int i = 0; i < 3; i++) begin
            flit_in = mk(2'b11, 3, 0);
            tick();
            n_cmp++; if (grnt_out !== 1'b0) begin n_bad++; $display("FAIL reset_grnt: got %0b need 0", grnt_out); end
            n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL reset_count: got %0d need 0", count); end
            n_cmp++; if (rc_req !== 3'b000) begin n_bad++; $display("FAIL reset_rc: got %03b need 000", rc_req); end
        end
        valid_in = 1'b0;
        reset = 1'b1;
        #1;
        n_cmp++; if (grnt_out !== 1'b1) begin n_bad++; $display("FAIL release_grnt: got %0b need 1", grnt_out); end
        n_cmp++; if (ovf !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got ovf=%0b err=%0b need 0/0", ovf, err); end
    endtask

    task automatic test_xy_route();
        int dxs[5];
        int dys[5];
        logic [2:0] exp_rc[5];
        logic [DATA_W-1:0] f;
        dxs = '{3, 1, 2, 2, 2};
        dys = '{0, 5, 4, 1, 2};
        exp_rc = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b001};
        for (int i = 0; i < 5; i++) begin
            f = mk(2'b11, dxs[i], dys[i]);
            flit_in = f;
            valid_in = 1'b1;
            tick();
            valid_in = 1'b0;
            n_cmp++; if (rc_req !== exp_rc[i]) begin n_bad++; $display("FAIL xy_rc[%0d]: got %03b need %03b", i, rc_req, exp_rc[i]); end
            n_cmp++; if (flit_out !== f) begin n_bad++; $display("FAIL xy_flit[%0d]: got %h need %h", i, flit_out, f); end
            n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL xy_count[%0d]: got %0d need 1", i, count); end
            sw_grant = 1'b1;
            tick();
            sw_grant = 1'b0;
            n_cmp++; if (count !== '0 || rc_req !== 3'b000) begin n_bad++; $display("FAIL xy_pop[%0d]: got count=%0d rc=%03b need 0/000", i, count, rc_req); end
        end
    endtask

    task automatic test_packet_hold();
        logic [DATA_W-1:0] pk[4];
        pk[0] = mk(2'b01, 3, 2);
        pk[1] = mk(2'b00, $urandom_range(0, 15), $urandom_range(0, 15));
        pk[2] = mk(2'b01, 0, 0);   // mid-packet flit that looks like a head
        pk[3] = mk(2'b10, $urandom_range(0, 15), $urandom_range(0, 15));
        for (int i = 0; i < 4; i++) begin
            flit_in = pk[i];
            valid_in = 1'b1;
            tick();
            n_cmp++; if (rc_req !== 3'b010) begin n_bad++; $display("FAIL pkt_fill_rc[%0d]: got %03b need 010", i, rc_req); end
        end
        valid_in = 1'b0;
        n_cmp++; if (count !== 3'd4) begin n_bad++; $display("FAIL pkt_count: got %0d need 4", count); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (flit_out !== pk[i]) begin n_bad++; $display("FAIL pkt_flit[%0d]: got %h need %h", i, flit_out, pk[i]); end
            n_cmp++; if (rc_req !== 3'b010) begin n_bad++; $display("FAIL pkt_hold_rc[%0d]: got %03b need 010", i, rc_req); end
            sw_grant = 1'b1;
            tick();
        end
        sw_grant = 1'b0;
        n_cmp++; if (rc_req !== 3'b000 || count !== '0) begin n_bad++; $display("FAIL pkt_end: got rc=%03b count=%0d need 000/0", rc_req, count); end
        // Back in IDLE: a fresh single flit must route on its own header.
        flit_in = mk(2'b11, 2, 2);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        n_cmp++; if (rc_req !== 3'b001) begin n_bad++; $display("FAIL pkt_idle_rc: got %03b need 001", rc_req); end
        sw_grant = 1'b1;
        tick();
        sw_grant = 1'b0;
    endtask

    task automatic test_full_overflow();
        logic [DATA_W-1:0] f[5];
        f[0] = mk(2'b01, $urandom_range(0, 4), $urandom_range(0, 4));
        f[1] = mk(2'b00, 1, 1);
        f[2] = mk(2'b00, 1, 1);
        f[3] = mk(2'b10, 1, 1);
        f[4] = mk(2'b11, 3, 3);
        for (int i = 0; i < 5; i++) begin
            flit_in = f[i];
            valid_in = 1'b1;
            tick();
            if (i == 3) begin
                n_cmp++; if (count !== 3'd4 || grnt_out !== 1'b0) begin n_bad++; $display("FAIL full_state: got count=%0d grnt=%0b need 4/0", count, grnt_out); end
                n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL full_early_ovf: got %0b need 0", ovf); end
            end
        end
        n_cmp++; if (count !== 3'd4 || ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_drop: got count=%0d ovf=%0b need 4/1", count, ovf); end
        n_cmp++; if (rc_req !== m_rc()) begin n_bad++; $display("FAIL full_rc: got %03b need %03b", rc_req, m_rc()); end
        // Grant and new flit together while full: pop only, no accept.
        flit_in = mk(2'b11, 0, 0);
        valid_in = 1'b1;
        sw_grant = 1'b1;
        n_cmp++; if (grnt_out !== 1'b0) begin n_bad++; $display("FAIL full_grant_same: got %0b need 0", grnt_out); end
        tick();
        valid_in = 1'b0;
        n_cmp++; if (count !== 3'd3 || grnt_out !== 1'b1) begin n_bad++; $display("FAIL full_pop: got count=%0d grnt=%0b need 3/1", count, grnt_out); end
        for (int i = 1; i < 4; i++) begin
            n_cmp++; if (flit_out !== f[i] || rc_req !== xy(f[0])) begin n_bad++; $display("FAIL full_drain[%0d]: got %h/%03b need %h/%03b", i, flit_out, rc_req, f[i], xy(f[0])); end
            tick();
        end
        sw_grant = 1'b0;
        n_cmp++; if (count !== '0 || rc_req !== 3'b000) begin n_bad++; $display("FAIL full_empty: got count=%0d rc=%03b need 0/000", count, rc_req); end
    endtask

    task automatic test_wrap();
        logic [DATA_W-1:0] s[10];
        valid_in = 1'b1;
        sw_grant = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s[i] = mk(2'b11, $urandom_range(0, 4), $urandom_range(0, 4));
            flit_in = s[i];
            tick();
            n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL wrap_count[%0d]: got %0d need 1", i, count); end
            n_cmp++; if (flit_out !== s[i]) begin n_bad++; $display("FAIL wrap_order[%0d]: got %h need %h", i, flit_out, s[i]); end
            n_cmp++; if (rc_req !== xy(s[i])) begin n_bad++; $display("FAIL wrap_rc[%0d]: got %03b need %03b", i, rc_req, xy(s[i])); end
        end
        valid_in = 1'b0;
        tick();
        sw_grant = 1'b0;
        n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL wrap_drain: got %0d need 0", count); end
    endtask

    task automatic test_protocol_err();
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_pre: got %0b need 0", err); end
        flit_in = mk(2'b00, 3, 3);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        n_cmp++; if (count !== 3'd1 || rc_req !== 3'b000) begin n_bad++; $display("FAIL err_body_head: got count=%0d rc=%03b need 1/000", count, rc_req); end
        tick();
        n_cmp++; if (count !== '0 || err !== 1'b1) begin n_bad++; $display("FAIL err_discard: got count=%0d err=%0b need 0/1", count, err); end
        flit_in = mk(2'b01, 0, 2);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        n_cmp++; if (rc_req !== 3'b011) begin n_bad++; $display("FAIL err_next_head: got %03b need 011", rc_req); end
        sw_grant = 1'b1;
        tick();
        sw_grant = 1'b0;
        flit_in = mk(2'b10, 4, 4);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        n_cmp++; if (rc_req !== 3'b011 || count !== 3'd1) begin n_bad++; $display("FAIL err_tail_rc: got %03b/%0d need 011/1", rc_req, count); end
        sw_grant = 1'b1;
        tick();
        sw_grant = 1'b0;
        n_cmp++; if (err !== 1'b1 || count !== '0) begin n_bad++; $display("FAIL err_sticky: got err=%0b count=%0d need 1/0", err, count); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            valid_in = ($urandom_range(0, 3) != 0);
            sw_grant = ($urandom_range(0, 2) == 0);
            flit_in  = mk(2'($urandom_range(0, 3)), $urandom_range(0, 4), $urandom_range(0, 4));
            n_cmp++; if (int'(count) != mq.size()) begin n_bad++; $display("FAIL rnd_count@%0d: got %0d need %0d", c, count, mq.size()); end
            n_cmp++; if (grnt_out !== (mq.size() < DEPTH)) begin n_bad++; $display("FAIL rnd_grnt@%0d: got %0b need %0b", c, grnt_out, mq.size() < DEPTH); end
            n_cmp++; if (rc_req !== m_rc()) begin n_bad++; $display("FAIL rnd_rc@%0d: got %03b need %03b", c, rc_req, m_rc()); end
            if (mq.size() != 0) begin
                n_cmp++; if (flit_out !== mq[0]) begin n_bad++; $display("FAIL rnd_flit@%0d: got %h need %h", c, flit_out, mq[0]); end
            end
            tick();
            n_cmp++; if (ovf !== m_ovf || err !== m_err) begin n_bad++; $display("FAIL rnd_flags@%0d: got ovf=%0b err=%0b need %0b/%0b", c, ovf, err, m_ovf, m_err); end
        end
        valid_in = 1'b0;
        sw_grant = 1'b0;
    endtask

    task automatic test_reset_mid();
        flit_in = mk(2'b01, 3, 0);
        valid_in = 1'b1;
        tick();
        flit_in = mk(2'b00, 0, 0);
        tick();
        valid_in = 1'b0;
        do_reset();
        n_cmp++; if (count !== '0 || rc_req !== 3'b000 || grnt_out !== 1'b0) begin n_bad++; $display("FAIL mid_reset: got count=%0d rc=%03b grnt=%0b need 0/000/0", count, rc_req, grnt_out); end
        n_cmp++; if (ovf !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL mid_flags: got ovf=%0b err=%0b need 0/0", ovf, err); end
        tick();
        reset = 1'b1;
        #1;
        flit_in = mk(2'b11, 1, 2);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        n_cmp++; if (rc_req !== 3'b011 || count !== 3'd1) begin n_bad++; $display("FAIL mid_resend: got rc=%03b count=%0d need 011/1", rc_req, count); end
        sw_grant = 1'b1;
        tick();
        sw_grant = 1'b0;
        n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL mid_drain: got %0d need 0", count); end
    endtask

    initial begin
        #2;
        test_reset();
        test_xy_route();
        test_packet_hold();
        test_full_overflow();
        test_wrap();
        test_protocol_err();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/inport_buf_rc.md
# inport_buf_rc

Input-port receiver for one router port (E/W/N/S/Local): the downstream end of the switch-allocator-to-neighbour flit handshake. Each instance accepts flits from the upstream router's grant/valid line into a small FIFO and returns the `grnt_in_*` ready signal upstream. It also performs XY route computation on head flits and presents the 3-bit route request (`rc*`) that the switch allocator consumes. It dequeues one flit each time the allocator grants this port.

## Interface
- `DATA_W`, 32, flit width; bits [DATA_W-1:DATA_W-2] = flit type.
- `DEPTH`, 4, FIFO entries (power of two, ≥2).
- `AW`, 2, log2(DEPTH).
- `COORD_W`, 4, width of each destination coordinate.
- `MY_X`, 0, this router's X coordinate.
- `MY_Y`, 0, this router's Y coordinate.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `valid_in`  in  1  upstream flit present this cycle (driven by the neighbour's `g*`).
- `flit_in`  in  DATA_W  incoming flit.
- `grnt_out`  out  1  ready to upstream; connects to the neighbour's `grnt_in_*`.
- `sw_grant`  in  1  allocator granted this port; pop the head flit.
- `flit_out`  out  DATA_W  FIFO head flit.
- `rc_req`  out  3  route request: 001 Local, 010 East, 011 West, 100 North, 101 South, 000 none.
- `count`  out  AW+1  FIFO occupancy.
- `ovf`  out  1  sticky: `valid_in` arrived while full.
- `err`  out  1  sticky: body or tail flit at head while IDLE.

## Operation
- **Flit types:** 01 head, 00 body, 10 tail, 11 single (head and tail in one flit).
- **Destination fields:**
  - dst_x = flit[DATA_W-3 -: COORD_W].
  - dst_y = flit[DATA_W-3-COORD_W -: COORD_W].
- **XY routing (unsigned compares):**
  - dst_x > MY_X → East; dst_x < MY_X → West.
  - Otherwise dst_y > MY_Y → North; dst_y < MY_Y → South.
  - Otherwise Local.
- **Ready:** `grnt_out` = reset & (count < DEPTH). It is combinational from current occupancy and ignores a same-cycle pop.
- **Push:** when `valid_in` & `grnt_out`. Write at wr_ptr, then wr_ptr+1 (wraps mod DEPTH).
- **Overflow:** `valid_in` while full → flit dropped, `ovf` set.
- **Pop:** when (`sw_grant` & count≠0) or (auto-discard). rd_ptr+1 (wraps mod DEPTH).
- **Grant on empty:** `sw_grant` while empty is ignored.
- **Occupancy:** push and pop in the same cycle leave `count` unchanged.
- **FSM states:** IDLE, ACTIVE. `route_q` is a 3-bit register.
  - IDLE, empty: `rc_req`=000.
  - IDLE, head at FIFO head is head or single: `rc_req` = XY(head), combinational.
  - IDLE, head at FIFO head is body or tail: `rc_req`=000, auto-discard pop that cycle, `err` set.
  - IDLE, pop of a head flit: `route_q` ← XY(head), go to ACTIVE.
  - IDLE, pop of a single flit: stay IDLE.
  - ACTIVE: `rc_req` = `route_q` if count≠0, else 000.
  - ACTIVE, pop of a tail flit: go to IDLE.
  - ACTIVE, head or single at FIFO head: treated as body; route unchanged.
- **flit_out:** always mem[rd_ptr]. Undefined content when empty, but stable.

## Timing
- **Reset (`reset`=0):** ptrs=0, `count`=0, state=IDLE, `route_q`=000, `ovf`=0, `err`=0. Resulting outputs: `grnt_out`=0 while asserted, 1 in the first cycle after release; `rc_req`=000.
- **Latency:** a flit pushed at edge N is visible on `flit_out`/`rc_req` after edge N. There is no bypass path.
- **Full/grant:** if full and `sw_grant` arrive in the same cycle, `grnt_out` stays 0 that cycle; the freed slot is offered the next cycle.
- **Allocator ordering:** `sw_grant` for a flit may arrive in the same cycle `rc_req` first shows it.
- **Reset mid-packet:** returns to IDLE and flushes the FIFO. Upstream must resend from a head flit.
- **Sticky flags:** `ovf` and `err` clear only on reset.

## Test plan
- **Reset:** hold `reset`=0 three cycles with `valid_in`=1 → `grnt_out`=0, `count`=0, `rc_req`=000. After release, `grnt_out`=1.
- **XY route:** MY_X=2, MY_Y=2. Push single flits with (dst_x,dst_y) = (3,0), (1,5), (2,4), (2,1), (2,2) → `rc_req` = 010, 011, 100, 101, 001, each popped by `sw_grant`. `count` ends at 0.
- **Packet hold:** push head(3,2), body, body, tail → `rc_req`=010 for all four flits across pops, including while the body at head looks like a head. After the tail pops, `rc_req`=000 and state is IDLE.
- **Full/overflow:** push 5 flits with no grant → `count`=4, `grnt_out`=0 after the 4th, 5th flit dropped, `ovf`=1. Then `sw_grant` and `valid_in` together while full → `count`=3 next cycle, and the flit is not accepted that cycle.
- **Wrap and simultaneous push/pop:** stream 10 single flits with `sw_grant`=1 every cycle → `count` holds at 1 and `flit_out` order matches input order across the pointer wrap.
- **Protocol error:** push a body flit while IDLE → it is auto-discarded the next cycle, `err`=1, `rc_req`=000. A subsequent head flit routes normally.
